// File: rtl/m1_session_ctrl.sv
// Session controller that shares one M1 ticket FSM between two stations: round-robin
// start arbitration, M-pulse forwarding for the granted station, ack/idle/hold timeouts.
module m1_session_ctrl #(
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int HOLD_CYC    = 200_000_000,
  parameter int ACK_CYC     = 4,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       R,
  input  logic [1:0] req_t,
  input  logic [1:0] req_m,
  input  logic       m1_T,
  input  logic       m1_V,
  input  logic [1:0] m1_D,
  output logic       iT,
  output logic       iM,
  output logic       m1_clr,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] disp,
  output logic       timeout,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    ACK     = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4,
    CLEAR   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sel, sel_nxt;
  logic             ptr, ptr_nxt;
  logic             err_nxt;
  logic             im_nxt;
  logic             fwd;

  assign fwd = req_m[sel];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    err_nxt   = err;
    im_nxt    = 1'b0;
    timeout   = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_t != 2'b00) begin
          sel_nxt   = (req_t == 2'b11) ? ptr : req_t[1];
          state_nxt = START;
        end
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = ACK;
      end
      ACK: begin
        if (m1_T) begin
          cnt_nxt   = '0;
          state_nxt = COLLECT;
        end else if (cnt >= ACK_LIM) begin
          err_nxt   = 1'b1;
          state_nxt = CLEAR;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      COLLECT: begin
        // A V arriving together with the last idle cycle completes the sale rather than aborting it.
        if (m1_V) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else if (fwd) begin
          cnt_nxt = '0;
          im_nxt  = 1'b1;
        end else if (cnt >= TO_LIM) begin
          timeout   = 1'b1;
          state_nxt = CLEAR;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DONE: begin
        if (cnt >= HOLD_LIM) begin
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      CLEAR: begin
        cnt_nxt   = '0;
        ptr_nxt   = ~sel;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (R) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 1'b0;
      ptr   <= 1'b0;
      err   <= 1'b0;
      iM    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      err   <= err_nxt;
      iM    <= im_nxt;
    end
  end

  assign busy   = (state != IDLE);
  assign iT     = (state == START);
  assign m1_clr = (state == CLEAR);
  assign grant  = busy ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign disp   = busy ? m1_D : 2'b00;

endmodule
